// File: rtl/keypad_entry_ctrl.sv
// Keypad entry sequencer: debounces scanner codes into single press events and
// collects a BCD number through a start / entry / confirm dialogue.
module keypad_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int DIGITS          = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [3:0]                     key,
  input  logic                           value_ready,
  output logic [4*DIGITS-1:0]            value_bcd,
  output logic [$clog2(DIGITS+1)-1:0]    digit_count,
  output logic                           value_valid,
  output logic                           busy,
  output logic                           start_pulse,
  output logic                           clear_pulse,
  output logic                           overflow_pulse,
  output logic [1:0]                     state_dbg
);

  localparam logic [3:0] KEY_START   = 4'hA;
  localparam logic [3:0] KEY_CLEAR   = 4'hB;
  localparam logic [3:0] KEY_CONFIRM = 4'hC;
  localparam logic [3:0] KEY_NONE    = 4'hD;

  localparam int                 DC_W    = $clog2(DIGITS + 1);
  localparam logic [DC_W-1:0]    FULL    = DC_W'(DIGITS);
  localparam logic [CNT_W-1:0]   CNT_HIT = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ENTRY    = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  state_t             state;
  logic [3:0]         key_q;
  logic [3:0]         stable_key;
  logic [3:0]         stable_prev;
  logic [CNT_W-1:0]   cnt;
  logic               evt;
  logic [3:0]         evt_code;
  logic               evt_is_digit;

  assign state_dbg    = state;
  assign evt_is_digit = (evt_code <= 4'd9);

  // Debounce and press detection. An event needs the stable code to pass
  // through "no key" first, so sliding from one key to another is silent.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q       <= KEY_NONE;
      stable_key  <= KEY_NONE;
      stable_prev <= KEY_NONE;
      cnt         <= '0;
      evt         <= 1'b0;
      evt_code    <= KEY_NONE;
    end else begin
      key_q <= key;
      if (key != key_q) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      if ((key == key_q) && (cnt == CNT_HIT)) begin
        stable_key <= key_q;
      end
      stable_prev <= stable_key;
      evt         <= (stable_prev == KEY_NONE) && (stable_key != KEY_NONE);
      evt_code    <= stable_key;
    end
  end

  // Valid/ready: value_valid rises on confirm and holds, with value_bcd and
  // digit_count frozen, until value_ready is sampled high on a clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      value_bcd      <= '0;
      digit_count    <= '0;
      value_valid    <= 1'b0;
      busy           <= 1'b0;
      start_pulse    <= 1'b0;
      clear_pulse    <= 1'b0;
      overflow_pulse <= 1'b0;
    end else begin
      start_pulse    <= 1'b0;
      clear_pulse    <= 1'b0;
      overflow_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (evt && (evt_code == KEY_START)) begin
            state       <= ENTRY;
            busy        <= 1'b1;
            value_bcd   <= '0;
            digit_count <= '0;
            start_pulse <= 1'b1;
          end
        end
        ENTRY: begin
          if (evt) begin
            if (evt_is_digit) begin
              if (digit_count < FULL) begin
                value_bcd   <= {value_bcd[4*DIGITS-5:0], evt_code};
                digit_count <= digit_count + 1'b1;
              end else begin
                overflow_pulse <= 1'b1;
              end
            end else if (evt_code == KEY_CLEAR) begin
              value_bcd   <= '0;
              digit_count <= '0;
              clear_pulse <= 1'b1;
            end else if (evt_code == KEY_START) begin
              value_bcd   <= '0;
              digit_count <= '0;
              start_pulse <= 1'b1;
            end else if ((evt_code == KEY_CONFIRM) && (digit_count != '0)) begin
              state       <= WAIT_ACK;
              value_valid <= 1'b1;
            end
          end
        end
        WAIT_ACK: begin
          if (value_ready) begin
            state       <= IDLE;
            value_valid <= 1'b0;
            busy        <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          value_valid <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: directed dialogue scenarios followed by random
// key/bounce traffic, all checked each cycle against a behavioural model.
module tb_keypad_entry_ctrl;

  localparam int DEB    = 4;
  localparam int DIGITS = 4;
  localparam int KD     = 13;

  localparam int M_IDLE  = 0;
  localparam int M_ENTRY = 1;
  localparam int M_WAIT  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key;
  logic        value_ready;
  logic [15:0] value_bcd;
  logic [2:0]  digit_count;
  logic        value_valid;
  logic        busy;
  logic        start_pulse;
  logic        clear_pulse;
  logic        overflow_pulse;
  logic [1:0]  state_dbg;

  keypad_entry_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(3),
    .DIGITS(DIGITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key(key),
    .value_ready(value_ready),
    .value_bcd(value_bcd),
    .digit_count(digit_count),
    .value_valid(value_valid),
    .busy(busy),
    .start_pulse(start_pulse),
    .clear_pulse(clear_pulse),
    .overflow_pulse(overflow_pulse),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: run length of identical samples, a queue of press
  // events due two edges after the code becomes stable, and the digit list.
  typedef struct {
    int code;
    int due;
  } ev_t;

  int  m_last_key;
  int  m_run;
  int  m_stable;
  int  m_state;
  int  m_digits[$];
  ev_t m_evq[$];
  bit  m_start, m_clear, m_ovf;
  int  cyc = 0;

  int n_start, n_clear, n_ovf;
  logic ready_drv = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_bcd();
    logic [15:0] v = '0;
    foreach (m_digits[i]) v = (v << 4) | 16'(m_digits[i]);
    return v;
  endfunction

  task automatic model_edge(input int k, input bit r, input bit rs);
    ev_t ev;
    bit  have_ev = 0;
    m_start = 0; m_clear = 0; m_ovf = 0;
    if (rs) begin
      m_last_key = KD; m_run = 1; m_stable = KD; m_state = M_IDLE;
      m_digits.delete(); m_evq.delete();
      cyc++;
      return;
    end
    if (m_evq.size() > 0 && m_evq[0].due == cyc) begin
      ev = m_evq.pop_front();
      have_ev = 1;
    end
    if (m_state == M_WAIT) begin
      if (r) m_state = M_IDLE;
    end else if (have_ev) begin
      if (m_state == M_IDLE) begin
        if (ev.code == 10) begin
          m_state = M_ENTRY; m_digits.delete(); m_start = 1;
        end
      end else begin
        if (ev.code <= 9) begin
          if (m_digits.size() < DIGITS) m_digits.push_back(ev.code);
          else m_ovf = 1;
        end else if (ev.code == 11) begin
          m_digits.delete(); m_clear = 1;
        end else if (ev.code == 10) begin
          m_digits.delete(); m_start = 1;
        end else if (ev.code == 12 && m_digits.size() > 0) begin
          m_state = M_WAIT;
        end
      end
    end
    if (k == m_last_key) m_run++;
    else m_run = 1;
    m_last_key = k;
    if (m_run > DEB && m_stable != k) begin
      if (m_stable == KD && k != KD) begin
        ev.code = k; ev.due = cyc + 2;
        m_evq.push_back(ev);
      end
      m_stable = k;
    end
    cyc++;
  endtask

  task automatic check_all();
    check("value_bcd", 32'(value_bcd), 32'(model_bcd()));
    check("digit_count", 32'(digit_count), 32'(m_digits.size()));
    check("value_valid", 32'(value_valid), 32'(m_state == M_WAIT));
    check("busy", 32'(busy), 32'(m_state != M_IDLE));
    check("start_pulse", 32'(start_pulse), 32'(m_start));
    check("clear_pulse", 32'(clear_pulse), 32'(m_clear));
    check("overflow_pulse", 32'(overflow_pulse), 32'(m_ovf));
  endtask

  task automatic tick(input logic [3:0] k, input logic r, input logic rs);
    key = k; value_ready = r; rst = rs;
    @(posedge clk);
    model_edge(int'(k), r, rs);
    #1;
    if (start_pulse === 1'b1) n_start++;
    if (clear_pulse === 1'b1) n_clear++;
    if (overflow_pulse === 1'b1) n_ovf++;
    check_all();
  endtask

  task automatic press(input logic [3:0] k, input int hold, input int gap);
    for (int i = 0; i < hold; i++) tick(k, ready_drv, 1'b0);
    for (int i = 0; i < gap; i++) tick(4'hD, ready_drv, 1'b0);
  endtask

  initial begin
    key = 4'hD; value_ready = 1'b0; rst = 1'b1;

    // Reset, then an ignored digit while idle
    tick(4'hD, 1'b0, 1'b1);
    tick(4'hD, 1'b0, 1'b1);
    check("reset_bcd", 32'(value_bcd), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_valid", 32'(value_valid), 32'h0);
    n_start = 0; n_clear = 0; n_ovf = 0;
    press(4'h7, 10, 8);
    check("idle_digit_busy", 32'(busy), 32'h0);
    check("idle_digit_pulses", 32'(n_start + n_clear + n_ovf), 32'h0);

    // Start press: pulse exactly at the sixth edge after the first A sample
    for (int i = 0; i < 10; i++) begin
      tick(4'hA, 1'b0, 1'b0);
      check("start_timing", 32'(start_pulse), 32'(i == 6));
    end
    press(4'hD, 0, 8);
    check("start_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 8; i++) press(4'hA, 2, 2);
    press(4'hD, 0, 8);
    check("bounce_no_extra_start", 32'(n_start), 32'h1);

    // Digit entry and overflow
    press(4'h1, 8, 8);
    press(4'h2, 8, 8);
    press(4'h3, 8, 8);
    check("entry_123_bcd", 32'(value_bcd), 32'h0123);
    check("entry_123_count", 32'(digit_count), 32'h3);
    press(4'h4, 8, 8);
    press(4'h5, 8, 8);
    check("full_bcd", 32'(value_bcd), 32'h1234);
    check("full_count", 32'(digit_count), 32'h4);
    check("overflow_seen", 32'(n_ovf), 32'h1);

    // Clear, then confirm on an empty buffer
    press(4'hB, 8, 8);
    check("clear_seen", 32'(n_clear), 32'h1);
    check("clear_bcd", 32'(value_bcd), 32'h0);
    press(4'hC, 8, 8);
    check("empty_confirm_busy", 32'(busy), 32'h1);
    check("empty_confirm_valid", 32'(value_valid), 32'h0);

    // Confirm with a stalled consumer, then handshake
    press(4'h9, 8, 8);
    press(4'h8, 8, 8);
    ready_drv = 1'b0;
    press(4'hC, 8, 20);
    press(4'h3, 8, 8);
    press(4'h7, 8, 8);
    check("stall_valid", 32'(value_valid), 32'h1);
    check("stall_bcd", 32'(value_bcd), 32'h0098);
    tick(4'hD, 1'b1, 1'b0);
    check("ack_valid", 32'(value_valid), 32'h0);
    check("ack_busy", 32'(busy), 32'h0);
    check("ack_retained", 32'(value_bcd), 32'h0098);
    tick(4'hD, 1'b0, 1'b0);

    // Key slide without release, then reset mid-entry
    press(4'hA, 8, 8);
    press(4'h5, 8, 0);
    press(4'h6, 8, 8);
    check("slide_bcd", 32'(value_bcd), 32'h0005);
    check("slide_count", 32'(digit_count), 32'h1);
    press(4'h2, 8, 0);
    tick(4'hD, 1'b0, 1'b1);
    check("midreset_busy", 32'(busy), 32'h0);
    check("midreset_bcd", 32'(value_bcd), 32'h0);
    check("midreset_count", 32'(digit_count), 32'h0);

    // Random traffic including bounces, stalls and occasional resets
    for (int s = 0; s < 400; s++) begin
      int sel;
      logic [3:0] k;
      sel = int'($urandom_range(0, 19));
      if (sel < 10) k = 4'(sel);
      else if (sel < 12) k = 4'hA;
      else if (sel < 13) k = 4'hB;
      else if (sel < 15) k = 4'hC;
      else if (sel < 16) k = 4'hF;
      else k = 4'hD;
      ready_drv = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 99) == 0) tick(4'hD, ready_drv, 1'b1);
      press(k, int'($urandom_range(1, 8)), int'($urandom_range(0, 8)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
